// File: rtl/gray_code_counter.sv
// 4-bit Gray-code sequence generator with a valid/ready output handshake.
// Supports up/down counting, a loadable start value and one-shot termination.
module gray_code_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       up_dn,
  input  logic       one_shot,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       out_ready,
  output logic       g3,
  output logic       g2,
  output logic       g1,
  output logic       g0,
  output logic       out_valid,
  output logic       wrap,
  output logic       busy
);

  localparam int unsigned W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   g_q;
  logic           wrap_q, wrap_d;
  logic           valid_q;
  logic           busy_q;
  logic           xfer;
  logic           at_term;

  // A transfer needs the RUN state (out_valid) and consumer acceptance.
  assign xfer    = (state_q == ST_RUN) && out_ready;
  assign at_term = up_dn ? (b_q == {W{1'b1}}) : (b_q == {W{1'b0}});

  // Next-state logic; load overrides everything except reset.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    wrap_d  = 1'b0;
    if (load) begin
      b_d     = load_val;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (!stop && start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (xfer) begin
            if (at_term && one_shot) begin
              state_d = ST_DONE;
            end else begin
              b_d    = up_dn ? (b_q + W'(1)) : (b_q - W'(1));
              wrap_d = at_term;
            end
          end
          if (stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Gray register tracks the binary register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      g_q     <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      g_q     <= b_d ^ (b_d >> 1);
      wrap_q  <= wrap_d;
      valid_q <= (state_d == ST_RUN);
      busy_q  <= (state_d == ST_RUN);
    end
  end

  assign {g3, g2, g1, g0} = g_q;
  assign out_valid        = valid_q;
  assign wrap             = wrap_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter: directed scenarios then random
// stimulus, all compared against a cycle-level reference model.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst, start, stop, up_dn, one_shot, load, out_ready;
  logic [3:0] load_val;
  logic       g3, g2, g1, g0, out_valid, wrap, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: count value, state (0 idle, 1 run, 2 done), wrap pulse.
  int   m_b   = 0;
  int   m_st  = 0;
  logic m_wrap = 1'b0;

  // Gray sequence written out literally, index = binary count.
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_code_counter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .up_dn     (up_dn),
    .one_shot  (one_shot),
    .load      (load),
    .load_val  (load_val),
    .out_ready (out_ready),
    .g3        (g3),
    .g2        (g2),
    .g1        (g1),
    .g0        (g0),
    .out_valid (out_valid),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gcode();
    return {g3, g2, g1, g0};
  endfunction

  // Same decoding the downstream grey_to_binary converter performs.
  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the applied inputs, then compare.
  task automatic cyc();
    logic [3:0] g_prev;
    bit         adv;
    bit         term;
    g_prev = gcode();
    adv    = 1'b0;
    @(posedge clk);
    if (rst) begin
      m_b = 0; m_st = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_b = int'(load_val); m_st = 0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (m_st == 1) begin
        if (out_ready) begin
          term = up_dn ? (m_b == 15) : (m_b == 0);
          if (term && one_shot) begin
            m_st = 2;
          end else begin
            m_b    = (m_b + (up_dn ? 1 : 15)) % 16;
            m_wrap = term;
            adv    = 1'b1;
          end
        end
        if (stop) m_st = 0;
      end else if (!stop && start) begin
        m_st = 1;
      end
    end
    #1;
    chk("code",      32'(gcode()),   32'(gtab[m_b]));
    chk("out_valid", 32'(out_valid), 32'(m_st == 1));
    chk("busy",      32'(busy),      32'(m_st == 1));
    chk("wrap",      32'(wrap),      32'(m_wrap));
    if (adv) chk("one_bit_step", 32'($countones(g_prev ^ gcode())), 32'd1);
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; stop = 0; load = 0; one_shot = 0;
    up_dn = 1; out_ready = 0; load_val = 4'd0;
  endtask

  initial begin
    idle_inputs();

    // Reset held two cycles with start asserted.
    rst = 1; start = 1;
    cyc(); cyc();
    chk("reset_code",  32'(gcode()),   32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    rst = 0; start = 0;
    cyc();
    chk("start_ignored_in_reset", 32'(busy), 32'd0);

    // Full up sequence with backpressure at 0110.
    start = 1; cyc(); start = 0;
    chk("run_presents_0", 32'(gcode()), 32'd0);
    up_dn = 1; out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          cyc();
          chk("bp_hold_code",  32'(gcode()),   32'b0110);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1;
      end
      cyc();
      chk("up_decode", 32'(g2b(gcode())), 32'(i % 16));
      chk("up_wrap",   32'(wrap),         32'(i == 16));
      if (i == 5) chk("bp_next_code", 32'(gcode()), 32'b0111);
    end
    out_ready = 0;
    cyc();
    chk("wrap_one_cycle", 32'(wrap), 32'd0);

    // Down count from a loaded value.
    load_val = 4'b0010; load = 1; cyc(); load = 0;
    chk("load_idle", 32'(out_valid), 32'd0);
    start = 1; cyc(); start = 0;
    chk("down_start_code", 32'(gcode()), 32'b0011);
    up_dn = 0; out_ready = 1;
    cyc(); chk("down_1", 32'(gcode()), 32'b0001);
    cyc(); chk("down_2", 32'(gcode()), 32'b0000); chk("down_nowrap", 32'(wrap), 32'd0);
    cyc(); chk("down_3", 32'(gcode()), 32'b1000); chk("down_wrap", 32'(wrap), 32'd1);

    // One-shot termination at the up terminal code.
    out_ready = 0; up_dn = 1;
    load_val = 4'd14; load = 1; cyc(); load = 0;
    one_shot = 1; start = 1; cyc(); start = 0;
    chk("os_start", 32'(gcode()), 32'b1001);
    out_ready = 1;
    cyc(); chk("os_term_code", 32'(gcode()), 32'b1000);
    cyc();
    chk("os_done_valid", 32'(out_valid), 32'd0);
    chk("os_done_busy",  32'(busy),      32'd0);
    chk("os_done_code",  32'(gcode()),   32'b1000);
    chk("os_no_wrap",    32'(wrap),      32'd0);
    cyc(); cyc();
    start = 1; cyc(); start = 0;
    chk("os_reoffer", 32'(gcode()), 32'b1000);
    chk("os_reoffer_valid", 32'(out_valid), 32'd1);

    // load + stop together with a pending transfer: load wins.
    one_shot = 0; out_ready = 1;
    load_val = 4'd5; load = 1; stop = 1; cyc(); load = 0; stop = 0;
    chk("prio_load_code",  32'(gcode()),   32'b0111);
    chk("prio_load_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN discards the transfer.
    start = 1; cyc(); start = 0; cyc();
    rst = 1; cyc(); rst = 0;
    chk("midrun_rst_code", 32'(gcode()), 32'd0);
    chk("midrun_rst_busy", 32'(busy),    32'd0);

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      load      = ($urandom_range(0, 24) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      start     = ($urandom_range(0, 3) == 0);
      one_shot  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      load_val  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_code_counter.md
# gray_code_counter

4-bit Gray-code sequence generator. It sits directly upstream of the `grey_to_binary` converter and drives its `g3..g0` inputs one code per accepted transfer. Counting is up or down, the start value is loadable, and a one-shot mode stops at the terminal code. A valid/ready handshake lets the consumer stall the sequence.

## Interface
Parameters: none; width is fixed at 4 bits to match the converter's `g3..g0` inputs.

- `clk` — in, 1: single clock; all state changes on its rising edge.
- `rst` — in, 1: reset; synchronous and active-high.
- `start` — in, 1: level-sampled; moves IDLE/DONE to RUN.
- `stop` — in, 1: level-sampled; moves RUN to IDLE.
- `up_dn` — in, 1: 1 counts up, 0 counts down; sampled on each handshake.
- `one_shot` — in, 1: 1 stops at the terminal code instead of wrapping; sampled on each handshake.
- `load` — in, 1: loads `load_val` into the counter; accepted in any state.
- `load_val` — in, 4: binary start value.
- `out_ready` — in, 1: consumer accepts the current code.
- `g3`, `g2`, `g1`, `g0` — out, 1 each: current Gray code, MSB first.
- `out_valid` — out, 1: the code on `g3..g0` is offered to the consumer.
- `wrap` — out, 1: one-cycle pulse when the sequence wraps.
- `busy` — out, 1: high in RUN.

## Operation
- Internal binary register `b[3:0]`. Output register `g` always equals `b ^ (b >> 1)`; `g` is updated in the same edge as `b`.
- Handshake: a transfer occurs in a cycle with `out_valid && out_ready`.
- Per transfer: `b` becomes `b+1` if `up_dn=1`, else `b-1`, modulo 16.
- Terminal code: binary 15 (Gray 1000) when counting up; binary 0 (Gray 0000) when counting down.
- States:
  - IDLE: `out_valid=0`, `busy=0`. `start` goes to RUN.
  - RUN: `out_valid=1`, `busy=1`.
    - Transfer at a non-terminal code: advance `b`.
    - Transfer at the terminal code with `one_shot=0`: advance (wrap) and pulse `wrap`.
    - Transfer at the terminal code with `one_shot=1`: no advance, go to DONE.
    - `stop`: go to IDLE. If a transfer happens in the same cycle, it still completes and advances.
  - DONE: `out_valid=0`, `busy=0`, code held. `start` goes to RUN with the code unchanged.
- Input priority: `rst` > `load` > `stop` > `start`.
- `load` (any state):
  - Sets `b=load_val` and the state to IDLE.
  - Forces `out_valid=0` and `wrap=0`, and drops any transfer in that cycle.
  - To load and run, assert `load`, then `start` on a later cycle.
- Reset values: `b=0000`, `g3..g0=0000`, `out_valid=0`, `wrap=0`, `busy=0`, state IDLE.
- Reset mid-RUN: the next cycle shows the reset values; a transfer in the reset cycle is discarded.
- `out_valid` never drops in RUN except via `stop`, `load`, `rst` or the one-shot terminal transfer.
- Consecutive codes differ in exactly one bit, including across the wrap.

## Timing
- `start` sampled at edge n: `out_valid=1` and `busy=1` from cycle n+1, presenting the held code.
- Transfer at edge n: the new code appears on `g3..g0` in cycle n+1. Throughput is one code per cycle when `out_ready=1`.
- `wrap` is high only in the cycle where the wrapped code first appears:
  - up: Gray 1000 → 0000;
  - down: Gray 0000 → 1000.
- While `out_valid=1` and `out_ready=0`, `g3..g0` is stable. `up_dn` changes have no effect until a transfer.
- `stop` or `load` at edge n: `out_valid=0` in cycle n+1.
- One-shot terminal transfer at edge n: `out_valid=0` and `busy=0` in cycle n+1; state DONE.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with `start=1`. Require `g=0000`, `out_valid=0`, `wrap=0`, `busy=0`; `start` is ignored.
- **Full up sequence:** `start`, `up_dn=1`, `out_ready=1`, 16 transfers. Require the code sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000 with `wrap=1` for exactly one cycle. Feeding `grey_to_binary` must yield 0..15. Every step is a single-bit change.
- **Backpressure:** at code 0110 hold `out_ready=0` for 3 cycles. Require `g=0110` and `out_valid=1` throughout. The next transfer gives 0111.
- **Down count:** `load_val=0010`, `load`, then `start`, `up_dn=0`. Require 0011 → 0001 → 0000 → 1000, with `wrap=1` only on 1000.
- **One-shot:** `load_val=1110`, `one_shot=1`, up. Require 1001 → 1000; after the 1000 transfer `out_valid=0`, `busy=0`, `g` holds 1000, and `wrap` stays 0. A later `start` re-offers 1000.
- **Priority and mid-run events:**
  - `load` and `stop` asserted together with a pending transfer: the load wins, the transfer is dropped, and the state is IDLE.
  - `rst` asserted mid-RUN: all outputs return to their reset values next cycle.
